// File: rtl/dk_ioctl_pkg.sv
// Shared ioctl definitions: upload-side state encoding, well-known ioctl
// index values and the 25-bit HPS ioctl byte address type.
package dk_ioctl_pkg;

  localparam int unsigned IOCTL_AW = 25;

  localparam logic [7:0] IOCTL_IDX_ROM   = 8'd0;
  localparam logic [7:0] IOCTL_IDX_MOD   = 8'd1;
  localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd4;
  localparam logic [7:0] IOCTL_IDX_DIP   = 8'd254;

  typedef logic [IOCTL_AW-1:0] ioctl_addr_t;

  typedef enum logic [2:0] {
    UPL_IDLE    = 3'd0,
    UPL_PAUSE   = 3'd1,
    UPL_READY   = 3'd2,
    UPL_FETCH   = 3'd3,
    UPL_LAT     = 3'd4,
    UPL_PRESENT = 3'd5
  } upl_state_t;

  // Saturating 16-bit increment used by the served-byte counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dk_ioctl_upload_if.sv
// HPS ioctl upload bus.
//   master (hps_io side): drives ioctl_upload/index/rd/addr, reads din/wait.
//   slave  (responder)  : reads the request, drives ioctl_din/ioctl_wait.
interface dk_ioctl_upload_if;

  logic                      ioctl_upload;
  logic [7:0]                ioctl_index;
  logic                      ioctl_rd;
  dk_ioctl_pkg::ioctl_addr_t ioctl_addr;
  logic [7:0]                ioctl_din;
  logic                      ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait
  );

endinterface

// File: rtl/dk_ioctl_upload.sv
// Read-side responder for the HPS ioctl upload channel. Pauses the CPU for
// the session, then answers each byte read from RAM port B (or FILL for
// addresses at/after LEN).
// Ports:
//   clk_sys, reset  : single clock, synchronous active-high reset
//   bus (slave)     : ioctl_upload/index/rd/addr in, ioctl_din/ioctl_wait out
//   pause_req/ack   : CPU halt handshake
//   ram_addr/rd/q   : RAM port-B read port, RD_LAT cycles rd -> q
//   busy, byte_cnt  : session status and bytes served this session
module dk_ioctl_upload
  import dk_ioctl_pkg::*;
#(
  parameter logic [7:0]  UPL_INDEX = IOCTL_IDX_NVRAM,
  parameter int unsigned AW        = 11,
  parameter int unsigned BASE      = 0,
  parameter int unsigned LEN       = 2048,
  parameter logic [7:0]  FILL      = 8'hFF,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  dk_ioctl_upload_if.slave      bus,
  output logic                  pause_req,
  input  logic                  pause_ack,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_rd,
  input  logic [7:0]            ram_q,
  output logic                  busy,
  output logic [15:0]           byte_cnt
);

  localparam ioctl_addr_t LEN_W    = IOCTL_AW'(LEN);
  localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);

  upl_state_t  state, state_nxt;
  logic [7:0]  din_q, din_nxt;
  logic        wait_q, wait_nxt;
  logic        pause_nxt;
  logic [AW-1:0] ram_addr_nxt;
  logic        ram_rd_nxt;
  logic        busy_nxt;
  logic [15:0] cnt_nxt;
  logic [1:0]  lat_cnt, lat_nxt;
  logic        pend, pend_nxt;
  ioctl_addr_t pend_addr, pend_addr_nxt;

  logic        start_c;
  logic        rd_go_c;
  ioctl_addr_t rd_addr_c;

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;

  assign start_c = bus.ioctl_upload && (bus.ioctl_index == UPL_INDEX);

  // A read captured together with pause_ack is replayed once READY is reached.
  assign rd_go_c   = pend || bus.ioctl_rd;
  assign rd_addr_c = pend ? pend_addr : bus.ioctl_addr;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    din_nxt       = din_q;
    wait_nxt      = wait_q;
    pause_nxt     = pause_req;
    ram_addr_nxt  = ram_addr;
    ram_rd_nxt    = 1'b0;
    cnt_nxt       = byte_cnt;
    lat_nxt       = lat_cnt;
    pend_nxt      = pend;
    pend_addr_nxt = pend_addr;

    unique case (state)
      UPL_IDLE: begin
        if (start_c) begin
          state_nxt = UPL_PAUSE;
          pause_nxt = 1'b1;
          wait_nxt  = 1'b1;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
        end
      end

      UPL_PAUSE: begin
        if (pause_ack) begin
          state_nxt = UPL_READY;
          wait_nxt  = 1'b0;
          if (bus.ioctl_rd) begin
            pend_nxt      = 1'b1;
            pend_addr_nxt = bus.ioctl_addr;
          end
        end
      end

      UPL_READY: begin
        if (rd_go_c) begin
          pend_nxt = 1'b0;
          // Full 25-bit compare: high address bits never alias into RAM.
          if (rd_addr_c < LEN_W) begin
            state_nxt    = UPL_FETCH;
            ram_rd_nxt   = 1'b1;
            ram_addr_nxt = AW'(BASE) + rd_addr_c[AW-1:0];
            wait_nxt     = 1'b1;
          end else begin
            state_nxt = UPL_PRESENT;
            din_nxt   = FILL;
            wait_nxt  = 1'b0;
            cnt_nxt   = sat_inc16(byte_cnt);
          end
        end
      end

      UPL_FETCH: begin
        state_nxt = UPL_LAT;
        lat_nxt   = '0;
      end

      UPL_LAT: begin
        if (lat_cnt == LAT_LAST) begin
          state_nxt = UPL_PRESENT;
          din_nxt   = ram_q;
          wait_nxt  = 1'b0;
          cnt_nxt   = sat_inc16(byte_cnt);
        end else begin
          lat_nxt = lat_cnt + 2'd1;
        end
      end

      UPL_PRESENT: begin
        state_nxt = UPL_READY;
      end

      default: begin
        state_nxt = UPL_IDLE;
      end
    endcase

    // Session end overrides everything; ioctl_din keeps its last value.
    if ((state != UPL_IDLE) && !bus.ioctl_upload) begin
      state_nxt  = UPL_IDLE;
      pause_nxt  = 1'b0;
      wait_nxt   = 1'b0;
      ram_rd_nxt = 1'b0;
      pend_nxt   = 1'b0;
      din_nxt    = din_q;
      cnt_nxt    = byte_cnt;
    end

    busy_nxt = (state_nxt != UPL_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= UPL_IDLE;
      din_q     <= 8'h00;
      wait_q    <= 1'b0;
      pause_req <= 1'b0;
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      busy      <= 1'b0;
      byte_cnt  <= '0;
      lat_cnt   <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      din_q     <= din_nxt;
      wait_q    <= wait_nxt;
      pause_req <= pause_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_rd    <= ram_rd_nxt;
      busy      <= busy_nxt;
      byte_cnt  <= cnt_nxt;
      lat_cnt   <= lat_nxt;
      pend      <= pend_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

  // Reads are legal only in READY, or together with pause_ack (then replayed).
  a_rd_when_ready: assert property (
    @(posedge clk_sys) disable iff (reset)
      bus.ioctl_rd |-> ((state == UPL_READY) || ((state == UPL_PAUSE) && pause_ack))
  );

endmodule

// File: tb/tb_dk_ioctl_upload.sv
// Directed bench for dk_ioctl_upload: table of single reads plus hand-written
// session, abort, replayed-read and reset sequences.
module tb_dk_ioctl_upload;
  import dk_ioctl_pkg::*;

  localparam int unsigned AW   = 12;
  localparam int unsigned BASE = 32'h400;
  localparam int unsigned LEN  = 2048;
  localparam int          NV   = 7;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          pause_req;
  logic          pause_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q;
  logic          busy;
  logic [15:0]   byte_cnt;

  logic [7:0] mem [0:4095];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [24:0]   addr;
    logic [7:0]    din;
    logic          mapped;
    logic [AW-1:0] raddr;
  } vec_t;

  vec_t vecs [NV];

  dk_ioctl_upload_if bus ();

  dk_ioctl_upload #(
    .UPL_INDEX (IOCTL_IDX_NVRAM),
    .AW        (AW),
    .BASE      (BASE),
    .LEN       (LEN),
    .FILL      (8'hFF),
    .RD_LAT    (1)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .pause_req (pause_req),
    .pause_ack (pause_ack),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_q     (ram_q),
    .busy      (busy),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // One-cycle-latency synchronous RAM model.
  always @(posedge clk_sys) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_din"},      32'(bus.ioctl_din),  32'h00);
    check({tag, "_wait"},     32'(bus.ioctl_wait), 32'd0);
    check({tag, "_pause"},    32'(pause_req),      32'd0);
    check({tag, "_ram_rd"},   32'(ram_rd),         32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr),       32'd0);
    check({tag, "_busy"},     32'(busy),           32'd0);
    check({tag, "_byte_cnt"}, 32'(byte_cnt),       32'd0);
  endtask

  // Open a matching session: ack raised two cycles after pause_req appears.
  task automatic open_session();
    bus.ioctl_index  = IOCTL_IDX_NVRAM;
    bus.ioctl_upload = 1'b1;
    tick();
    check("start_pause", 32'(pause_req),      32'd1);
    check("start_wait",  32'(bus.ioctl_wait), 32'd1);
    check("start_busy",  32'(busy),           32'd1);
    check("start_cnt",   32'(byte_cnt),       32'd0);
    repeat (2) begin
      tick();
      check("pause_wait", 32'(bus.ioctl_wait), 32'd1);
    end
    pause_ack = 1'b1;
    tick();
    check("ready_wait",  32'(bus.ioctl_wait), 32'd0);
    check("ready_pause", 32'(pause_req),      32'd1);
  endtask

  task automatic close_session();
    bus.ioctl_upload = 1'b0;
    pause_ack        = 1'b0;
    tick();
  endtask

  // Issue one read from READY and check the cycle-exact response; ends in READY.
  task automatic do_read(input logic [24:0] a, input logic [7:0] exp, input logic mapped,
                         input logic [AW-1:0] raddr);
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = a;
    tick();
    bus.ioctl_rd = 1'b0;
    if (mapped) begin
      check("t1_ram_rd",   32'(ram_rd),         32'd1);
      check("t1_ram_addr", 32'(ram_addr),       32'(raddr));
      check("t1_wait",     32'(bus.ioctl_wait), 32'd1);
      tick();
      check("t2_ram_rd",   32'(ram_rd),         32'd0);
      check("t2_wait",     32'(bus.ioctl_wait), 32'd1);
      tick();
      check("t3_wait",     32'(bus.ioctl_wait), 32'd0);
      check("t3_din",      32'(bus.ioctl_din),  32'(exp));
    end else begin
      check("unm_ram_rd",  32'(ram_rd),         32'd0);
      check("unm_wait",    32'(bus.ioctl_wait), 32'd0);
      check("unm_din",     32'(bus.ioctl_din),  32'(exp));
    end
    tick();
  endtask

  initial begin
    // mem[k] = (k >> 4) + 0x11, with RAM[0x410] = 0xA5 for the basic read.
    for (int k = 0; k < 4096; k++) mem[k] = 8'(k >> 4) + 8'h11;
    mem[12'h410] = 8'hA5;

    vecs[0] = '{25'h010,     8'hA5, 1'b1, 12'h410};
    vecs[1] = '{25'h000,     8'h51, 1'b1, 12'h400};
    vecs[2] = '{25'h7FF,     8'hD0, 1'b1, 12'hBFF};
    vecs[3] = '{25'h800,     8'hFF, 1'b0, 12'h000};
    vecs[4] = '{25'h1FFFFFF, 8'hFF, 1'b0, 12'h000};
    vecs[5] = '{25'h1000,    8'hFF, 1'b0, 12'h000};
    vecs[6] = '{25'h3FF,     8'h90, 1'b1, 12'h7FF};

    reset            = 1'b1;
    pause_ack        = 1'b0;
    ram_q            = 8'h00;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'd0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    repeat (2) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Wrong index: block stays idle.
    bus.ioctl_index  = IOCTL_IDX_ROM;
    bus.ioctl_upload = 1'b1;
    repeat (6) begin
      tick();
      check("wrong_idx_pause", 32'(pause_req),      32'd0);
      check("wrong_idx_wait",  32'(bus.ioctl_wait), 32'd0);
    end
    bus.ioctl_upload = 1'b0;
    tick();

    // Table of single reads in one session.
    open_session();
    for (int i = 0; i < NV; i++) begin
      do_read(vecs[i].addr, vecs[i].din, vecs[i].mapped, vecs[i].raddr);
      check("vec_byte_cnt", 32'(byte_cnt), 32'(i + 1));
    end

    // Abort while in LAT.
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 25'h030;
    tick();
    bus.ioctl_rd = 1'b0;
    tick();
    bus.ioctl_upload = 1'b0;
    tick();
    check("abort_pause",  32'(pause_req),      32'd0);
    check("abort_busy",   32'(busy),           32'd0);
    check("abort_wait",   32'(bus.ioctl_wait), 32'd0);
    check("abort_ram_rd", 32'(ram_rd),         32'd0);
    check("abort_din",    32'(bus.ioctl_din),  32'(vecs[NV-1].din));
    pause_ack = 1'b0;
    tick();

    // Sequential stream of 256 reads, RAM[0x400+i] = i.
    for (int i = 0; i < 256; i++) mem[BASE + i] = 8'(i);
    open_session();
    for (int i = 0; i < 256; i++) do_read(25'(i), 8'(i), 1'b1, AW'(BASE + i));
    check("stream_byte_cnt", 32'(byte_cnt), 32'd256);
    close_session();

    // Read issued in the same cycle as pause_ack is replayed after READY.
    bus.ioctl_index  = IOCTL_IDX_NVRAM;
    bus.ioctl_upload = 1'b1;
    tick();
    tick();
    pause_ack      = 1'b1;
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 25'h020;
    tick();
    bus.ioctl_rd = 1'b0;
    check("ack_rd_ready_wait", 32'(bus.ioctl_wait), 32'd0);
    check("ack_rd_no_ram_rd",  32'(ram_rd),         32'd0);
    tick();
    check("ack_rd_ram_rd",     32'(ram_rd),         32'd1);
    check("ack_rd_ram_addr",   32'(ram_addr),       32'h420);
    tick();
    tick();
    check("ack_rd_din",        32'(bus.ioctl_din),  32'h20);
    check("ack_rd_wait",       32'(bus.ioctl_wait), 32'd0);
    check("ack_rd_cnt",        32'(byte_cnt),       32'd1);
    tick();
    close_session();

    // Reset while in PAUSE.
    bus.ioctl_upload = 1'b1;
    tick();
    check("rp_pause_req", 32'(pause_req), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_vals("rp");
    reset            = 1'b0;
    bus.ioctl_upload = 1'b0;
    repeat (2) begin
      tick();
      check("rp_idle_pause", 32'(pause_req), 32'd0);
      check("rp_idle_busy",  32'(busy),      32'd0);
    end
    bus.ioctl_upload = 1'b1;
    tick();
    check("rp_restart_pause", 32'(pause_req), 32'd1);
    bus.ioctl_upload = 1'b0;
    tick();
    check("rp_end_pause", 32'(pause_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
